ysyx_23060201_dmem_resp: RTL and testbench

Data-memory responder for the NPC core: the slave end of the execute stage's load/store request interface. Accepts one load or store per handshake and holds word-organised storage with byte-lane writes. Returns size-extracted, optionally sign-extended load data after a configurable latency. Replaces the zero-latency DPI memory model so the core can be exercised against a multi-cycle, back-pressuring memory.

---
 rtl/ysyx_23060201_dmem_resp_if.sv | 26 ++
 rtl/ysyx_23060201_dmem_resp.sv | 94 +++++++++
 tb/tb_ysyx_23060201_dmem_resp.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_dmem_resp_if.sv
// ysyx_23060201_dmem_resp_if: load/store request and response bus between execute stage and data memory
interface ysyx_23060201_dmem_resp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic                  req_ren;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [7:0]            req_rmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  modport master(
    output req_valid, req_wen, req_ren, req_addr, req_wmask, req_wdata, req_rmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave(
    input  req_valid, req_wen, req_ren, req_addr, req_wmask, req_wdata, req_rmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_23060201_dmem_resp.sv
// ysyx_23060201_dmem_resp: multi-cycle data memory responder; YSYX_23060201_DMEM_RAND_DELAY_EN adds LFSR-jittered latency
module ysyx_23060201_dmem_resp #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_23060201_dmem_resp_if.slave s
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                r_state, w_next;
  logic [7:0]            r_cnt, w_load, r_wmask, r_rmask, w_wmask, w_rmask;
  logic                  r_wen, r_ren, r_valid, r_err, w_wen, w_ren, w_acc, w_enter, w_err, w_mask_ok;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr, w_off;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata, r_rdata, w_rdata, w_lane, w_shw, w_ld;
  logic [3:0]            w_size, w_be;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];
  // With zero wait the accept edge is also the commit edge, so decode the live bus while idle
  assign w_acc   = s.req_valid && s.req_ready;
  assign w_wen   = r_state == IDLE ? s.req_wen   : r_wen;
  assign w_ren   = r_state == IDLE ? s.req_ren   : r_ren;
  assign w_addr  = r_state == IDLE ? s.req_addr  : r_addr;
  assign w_wmask = r_state == IDLE ? s.req_wmask : r_wmask;
  assign w_rmask = r_state == IDLE ? s.req_rmask : r_rmask;
  assign w_wdata = r_state == IDLE ? s.req_wdata : r_wdata;
  assign w_off   = w_addr - BASE_ADDR;
  assign w_idx   = w_off[DEPTH_LOG2+1:2];
  assign w_size  = w_wen ? w_wmask[3:0] : w_rmask[3:0];
  assign w_mask_ok = w_wen ? (w_wmask inside {8'h01, 8'h03, 8'h0F})
                           : (w_rmask inside {8'h01, 8'h03, 8'h11, 8'h13, 8'h1F});
  assign w_err = (w_wen == w_ren) || (w_addr < BASE_ADDR) || (|(w_off >> (DEPTH_LOG2 + 2))) || !w_mask_ok
              || (w_size == 4'h3 && w_addr[0]) || (w_size == 4'hF && |w_addr[1:0]);
  assign w_be   = w_size << w_addr[1:0];
  assign w_lane = w_wdata << {w_addr[1:0], 3'b000};
  assign w_shw  = r_mem[w_idx] >> {w_addr[1:0], 3'b000};
  assign w_ld   = w_size == 4'h1 ? {{24{w_rmask[4] & w_shw[7]}}, w_shw[7:0]}
                : w_size == 4'h3 ? {{16{w_rmask[4] & w_shw[15]}}, w_shw[15:0]} : w_shw;
  assign w_rdata = (w_err || w_wen) ? '0 : w_ld;
`ifdef YSYX_23060201_DMEM_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= rst ? 8'hA5 : {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_load = 8'(LATENCY - 1) + {6'b0, r_lfsr[1:0]};
`else
  assign w_load = 8'(LATENCY - 1);
`endif
  always_comb begin
    w_next = r_state == IDLE ? (w_acc ? (w_load == 8'd0 ? RESP : WAIT) : IDLE)
           : r_state == WAIT ? (r_cnt == 8'd1 ? RESP : WAIT)
           : (s.resp_ready ? IDLE : RESP);
  end
  assign w_enter = w_next == RESP && r_state != RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_wen   <= s.req_wen;
        r_ren   <= s.req_ren;
        r_addr  <= s.req_addr;
        r_wmask <= s.req_wmask;
        r_rmask <= s.req_rmask;
        r_wdata <= s.req_wdata;
        r_cnt   <= w_load;
      end else if (r_state == WAIT) r_cnt <= r_cnt - 8'd1;
      if (w_enter) begin
        r_valid <= 1'b1;
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end else if (r_state == RESP && s.resp_ready) begin
        r_valid <= 1'b0;
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_enter && w_wen && !w_err)
      for (int b = 0; b < 4; b++) if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
  end
  assign s.req_ready  = r_state == IDLE && !rst;
  assign s.resp_valid = r_valid;
  assign s.resp_rdata = r_rdata;
  assign s.resp_err   = r_err;
endmodule

// File: tb/tb_ysyx_23060201_dmem_resp.sv
// tb_ysyx_23060201_dmem_resp: directed checks of load/store, errors, back-pressure and reset
module tb_ysyx_23060201_dmem_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass = 0;
  int total = 0;
  logic [31:0] rd;
  logic er;
  int lat;
  always #5 clk = ~clk;
  ysyx_23060201_dmem_resp_if bus();
  ysyx_23060201_dmem_resp dut(.clk(clk), .rst(rst), .s(bus));
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic xact(input logic wen, input logic ren, input logic [31:0] addr, input logic [7:0] wm,
                      input logic [31:0] wd, input logic [7:0] rm,
                      output logic [31:0] rdo, output logic ero, output int lato);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_ren   = ren;
    bus.req_addr  = addr;
    bus.req_wmask = wm;
    bus.req_wdata = wd;
    bus.req_rmask = rm;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lato = 1;
    while (!bus.resp_valid && lato < 50) begin
      @(posedge clk);
      #1 lato++;
    end
    rdo = bus.resp_rdata;
    ero = bus.resp_err;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_ren = 1'b0; bus.req_addr = '0;
    bus.req_wmask = '0; bus.req_wdata = '0; bus.req_rmask = '0; bus.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", bus.req_ready); else pass++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); else pass++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h want 0", bus.resp_rdata); else pass++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL rst_resp_err got %b want 0", bus.resp_err); else pass++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL idle_req_ready got %b want 1", bus.req_ready); else pass++;
  endtask
  task automatic test_word();
    xact(1, 0, 32'h8000_0000, 8'h0F, 32'hDEAD_BEEF, 8'h00, rd, er, lat);
    total++; if (lat !== 2) $display("FAIL word_store_latency got %0d want 2", lat); else pass++;
    total++; if (er !== 1'b0) $display("FAIL word_store_err got %b want 0", er); else pass++;
    total++; if (rd !== 32'h0) $display("FAIL word_store_rdata got %h want 0", rd); else pass++;
    xact(0, 1, 32'h8000_0000, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (lat !== 2) $display("FAIL word_load_latency got %0d want 2", lat); else pass++;
    total++; if (er !== 1'b0) $display("FAIL word_load_err got %b want 0", er); else pass++;
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL word_load_rdata got %h want deadbeef", rd); else pass++;
  endtask
  task automatic test_byte_lane();
    xact(1, 0, 32'h8000_0003, 8'h01, 32'h0000_0080, 8'h00, rd, er, lat);
    total++; if (er !== 1'b0) $display("FAIL byte_store_err got %b want 0", er); else pass++;
    xact(0, 1, 32'h8000_0003, 8'h00, 32'h0, 8'h11, rd, er, lat);
    total++; if (rd !== 32'hFFFF_FF80) $display("FAIL lb_signed got %h want ffffff80", rd); else pass++;
    xact(0, 1, 32'h8000_0003, 8'h00, 32'h0, 8'h01, rd, er, lat);
    total++; if (rd !== 32'h0000_0080) $display("FAIL lb_unsigned got %h want 00000080", rd); else pass++;
    xact(0, 1, 32'h8000_0000, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (rd !== 32'h80AD_BEEF) $display("FAIL lw_after_sb got %h want 80adbeef", rd); else pass++;
    xact(0, 1, 32'h8000_0002, 8'h00, 32'h0, 8'h13, rd, er, lat);
    total++; if (rd !== 32'hFFFF_80AD) $display("FAIL lh_signed got %h want ffff80ad", rd); else pass++;
    xact(0, 1, 32'h8000_0000, 8'h00, 32'h0, 8'h03, rd, er, lat);
    total++; if (rd !== 32'h0000_BEEF) $display("FAIL lh_unsigned got %h want 0000beef", rd); else pass++;
  endtask
  task automatic test_errors();
    xact(1, 0, 32'h8000_0001, 8'h03, 32'h0000_FFFF, 8'h00, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL misaligned_sh_err got %b want 1", er); else pass++;
    total++; if (rd !== 32'h0) $display("FAIL misaligned_sh_rdata got %h want 0", rd); else pass++;
    xact(1, 0, 32'h7FFF_FFFC, 8'h0F, 32'h0, 8'h00, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL below_base_err got %b want 1", er); else pass++;
    xact(1, 0, 32'h8000_4000, 8'h0F, 32'h0, 8'h00, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL above_top_err got %b want 1", er); else pass++;
    xact(1, 1, 32'h8000_0000, 8'h0F, 32'h0, 8'h1F, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL wen_ren_err got %b want 1", er); else pass++;
    total++; if (rd !== 32'h0) $display("FAIL wen_ren_rdata got %h want 0", rd); else pass++;
    xact(0, 0, 32'h8000_0000, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL no_op_err got %b want 1", er); else pass++;
    xact(0, 1, 32'h8000_0000, 8'h00, 32'h0, 8'h07, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL bad_rmask_err got %b want 1", er); else pass++;
    xact(0, 1, 32'h8000_0002, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL misaligned_lw_err got %b want 1", er); else pass++;
    xact(0, 1, 32'h8000_0000, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (rd !== 32'h80AD_BEEF) $display("FAIL mem_after_errors got %h want 80adbeef", rd); else pass++;
    total++; if (er !== 1'b0) $display("FAIL mem_after_errors_err got %b want 0", er); else pass++;
  endtask
  task automatic test_back_to_back();
    xact(1, 0, 32'h8000_0004, 8'h0F, 32'h1122_3344, 8'h00, rd, er, lat);
    xact(0, 1, 32'h8000_0004, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (rd !== 32'h1122_3344) $display("FAIL b2b_word got %h want 11223344", rd); else pass++;
    xact(1, 0, 32'h8000_0006, 8'h03, 32'h0000_A5A5, 8'h00, rd, er, lat);
    xact(0, 1, 32'h8000_0004, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (rd !== 32'hA5A5_3344) $display("FAIL b2b_half got %h want a5a53344", rd); else pass++;
  endtask
  task automatic test_backpressure();
    int n = 0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_ren = 1'b1;
    bus.req_addr = 32'h8000_0000; bus.req_rmask = 8'h1F;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (!bus.resp_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_ren = 1'b0;
    bus.req_wmask = 8'h0F; bus.req_wdata = 32'h0;
    repeat (5) begin
      @(negedge clk);
      total++; if (bus.resp_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", bus.resp_valid); else pass++;
      total++; if (bus.resp_rdata !== 32'h80AD_BEEF) $display("FAIL bp_rdata got %h want 80adbeef", bus.resp_rdata); else pass++;
      total++; if (bus.resp_err !== 1'b0) $display("FAIL bp_err got %b want 0", bus.resp_err); else pass++;
      total++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready got %b want 0", bus.req_ready); else pass++;
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", bus.resp_valid); else pass++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL bp_release_rdata got %h want 0", bus.resp_rdata); else pass++;
    xact(0, 1, 32'h8000_0000, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (rd !== 32'h80AD_BEEF) $display("FAIL bp_ignored_store got %h want 80adbeef", rd); else pass++;
  endtask
  task automatic test_reset_midop();
    xact(1, 0, 32'h8000_0010, 8'h0F, 32'hCAFE_F00D, 8'h00, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_ren = 1'b0;
    bus.req_addr = 32'h8000_0010; bus.req_wmask = 8'h0F; bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL midop_rst_valid got %b want 0", bus.resp_valid); else pass++;
    @(negedge clk);
    rst = 1'b0;
    xact(0, 1, 32'h8000_0010, 8'h00, 32'h0, 8'h1F, rd, er, lat);
    total++; if (rd !== 32'hCAFE_F00D) $display("FAIL midop_store_dropped got %h want cafef00d", rd); else pass++;
  endtask
  initial begin
    test_reset();
    test_word();
    test_byte_lane();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
